// File: rtl/video_trans_arp_ctrl_pkg.sv
// ============================================================================
// Module   : video_trans_arp_ctrl_pkg
// Purpose  : Shared ARP constants and controller state encoding for the
//            video Ethernet link.
// Contents : ARP opcode values, broadcast MAC, default peer IP, FSM states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package video_trans_arp_ctrl_pkg;

  localparam logic        ARP_OP_REQ    = 1'b0;
  localparam logic        ARP_OP_REP    = 1'b1;
  localparam logic [47:0] MAC_BCAST     = 48'hff_ff_ff_ff_ff_ff;
  localparam logic [31:0] DEF_PEER_IP   = {8'd192, 8'd168, 8'd1, 8'd102};
  localparam logic [31:0] DEF_BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10};
  localparam logic [47:0] DEF_BOARD_MAC = 48'h00_11_22_33_44_55;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUS  = 2'd1,
    ST_SEND      = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arp_state_t;

endpackage

`default_nettype wire

// File: rtl/video_trans_arp_ctrl.sv
// ============================================================================
// Module   : video_trans_arp_ctrl
// Purpose  : Sequences the ARP transceiver of the video Ethernet link.
//            Resolves the PC's MAC with retried broadcast requests, answers
//            ARP requests addressed to the board, and arbitrates the shared
//            GMII TX path against the UDP video transmitter.
// Ports    : clk, rst_n                  - GMII clock, async active-low reset
//            arp_rx_done/type, src_mac/ip - received ARP frame info
//            arp_req                     - force a new resolution
//            udp_busy                    - UDP transmitter owns TX path
//            arp_tx_en/type, des_mac/ip  - ARP transmitter command
//            tx_done                     - ARP frame fully sent
//            arp_busy                    - ARP owns TX path
//            peer_mac/valid, retry_cnt   - resolution status
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_trans_arp_ctrl
  import video_trans_arp_ctrl_pkg::*;
#(
  parameter logic [31:0] DES_IP      = DEF_PEER_IP,
  parameter logic [31:0] STARTUP_CYC = 32'd12_500_000,
  parameter logic [31:0] RETRY_CYC   = 32'd125_000_000,
  parameter logic [15:0] TX_TIMEOUT  = 16'd4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arp_rx_done,
  input  logic        arp_rx_type,
  input  logic [47:0] src_mac,
  input  logic [31:0] src_ip,
  input  logic        arp_req,
  input  logic        udp_busy,
  output logic        arp_tx_en,
  output logic        arp_tx_type,
  output logic [47:0] des_mac,
  output logic [31:0] des_ip,
  input  logic        tx_done,
  output logic        arp_busy,
  output logic [47:0] peer_mac,
  output logic        peer_valid,
  output logic [7:0]  retry_cnt
);

  arp_state_t  r_state;
  arp_state_t  w_next;
  logic [31:0] r_timer;
  logic [15:0] r_wd;
  logic        r_req_pend;
  logic        r_rep_pend;
  logic [47:0] r_rep_mac;
  logic [31:0] r_rep_ip;

  logic        w_pend_req;
  logic        w_go_send;
  logic        w_send_rep;
  logic        w_wd_to;
  logic        w_rx_req;
  logic        w_peer_hit;
  logic        w_timer_fire;

  assign w_rx_req     = arp_rx_done && (arp_rx_type == ARP_OP_REQ);
  assign w_peer_hit   = arp_rx_done && (arp_rx_type == ARP_OP_REP) && (src_ip == DES_IP);
  // Timer only runs while unresolved; "reaching 0" is the decrement from 1.
  assign w_timer_fire = !arp_req && !peer_valid && (r_timer <= 32'd1);
  // A request is only worth sending while the peer is still unresolved.
  assign w_pend_req   = r_req_pend && !peer_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_go_send  = 1'b0;
    w_send_rep = 1'b0;
    w_wd_to    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_rep_pend || w_pend_req) w_next = ST_WAIT_BUS;
      end
      ST_WAIT_BUS: begin
        // The pending work can vanish while waiting (peer reply clears
        // req_pend); release the bus rather than send an empty frame.
        if (!(r_rep_pend || w_pend_req)) begin
          w_next = ST_IDLE;
        end else if (!udp_busy) begin
          w_next     = ST_SEND;
          w_go_send  = 1'b1;
          w_send_rep = r_rep_pend;
        end
      end
      ST_SEND: begin
        w_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (tx_done) begin
          w_next = ST_IDLE;
        end else if (r_wd >= TX_TIMEOUT - 16'd1) begin
          w_next  = ST_IDLE;
          w_wd_to = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Command outputs are loaded on the edge entering SEND so that they are
  // valid together with the arp_tx_en pulse and held until the next SEND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arp_tx_en   <= 1'b0;
      arp_tx_type <= ARP_OP_REQ;
      des_mac     <= MAC_BCAST;
      des_ip      <= DES_IP;
      arp_busy    <= 1'b0;
      r_wd        <= 16'd0;
    end else begin
      arp_tx_en <= w_go_send;
      arp_busy  <= (w_next != ST_IDLE);
      if (r_state == ST_SEND)           r_wd <= 16'd0;
      else if (r_state == ST_WAIT_DONE) r_wd <= r_wd + 16'd1;
      if (w_go_send) begin
        if (w_send_rep) begin
          arp_tx_type <= ARP_OP_REP;
          des_mac     <= r_rep_mac;
          des_ip      <= r_rep_ip;
        end else begin
          arp_tx_type <= ARP_OP_REQ;
          des_mac     <= MAC_BCAST;
          des_ip      <= DES_IP;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer    <= STARTUP_CYC;
      r_req_pend <= 1'b0;
      r_rep_pend <= 1'b0;
      r_rep_mac  <= 48'd0;
      r_rep_ip   <= 32'd0;
      peer_mac   <= 48'd0;
      peer_valid <= 1'b0;
      retry_cnt  <= 8'd0;
    end else begin
      if (arp_req)           r_timer <= RETRY_CYC;
      else if (w_timer_fire) r_timer <= RETRY_CYC;
      else if (!peer_valid)  r_timer <= r_timer - 32'd1;

      if (arp_req)                     r_req_pend <= 1'b1;
      else if (w_peer_hit)             r_req_pend <= 1'b0;
      else if (w_timer_fire)           r_req_pend <= 1'b1;
      else if (w_go_send && !w_send_rep) r_req_pend <= 1'b0;

      // A freshly received request outranks the clear from the reply being
      // loaded this cycle, so it is not lost.
      if (w_rx_req)                                    r_rep_pend <= 1'b1;
      else if (w_wd_to && (arp_tx_type == ARP_OP_REP)) r_rep_pend <= 1'b1;
      else if (w_go_send && w_send_rep)                r_rep_pend <= 1'b0;

      if (w_rx_req) begin
        r_rep_mac <= src_mac;
        r_rep_ip  <= src_ip;
      end

      if (w_peer_hit) peer_mac <= src_mac;

      if (arp_req)         peer_valid <= 1'b0;
      else if (w_peer_hit) peer_valid <= 1'b1;

      if (arp_req)
        retry_cnt <= 8'd0;
      else if (w_go_send && !w_send_rep && (retry_cnt != 8'hff))
        retry_cnt <= retry_cnt + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_video_trans_arp_ctrl.sv
// ============================================================================
// Module   : tb_video_trans_arp_ctrl
// Purpose  : Scoreboard bench for video_trans_arp_ctrl with shortened timers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_video_trans_arp_ctrl;

  localparam logic [31:0] DES_IP   = 32'hc0a80166;
  localparam logic [31:0] STARTUP  = 32'd40;
  localparam logic [31:0] RETRY    = 32'd60;
  localparam logic [15:0] TXTO     = 16'd32;
  localparam logic [47:0] BCAST    = 48'hffffffffffff;
  localparam logic [47:0] PEER_MAC = 48'h0a0b0c0d0e0f;

  logic        clk, rst_n;
  logic        arp_rx_done, arp_rx_type;
  logic [47:0] src_mac;
  logic [31:0] src_ip;
  logic        arp_req, udp_busy, tx_done;
  logic        arp_tx_en, arp_tx_type, arp_busy, peer_valid;
  logic [47:0] des_mac, peer_mac;
  logic [31:0] des_ip;
  logic [7:0]  retry_cnt;

  video_trans_arp_ctrl #(
    .DES_IP(DES_IP), .STARTUP_CYC(STARTUP), .RETRY_CYC(RETRY), .TX_TIMEOUT(TXTO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arp_rx_done(arp_rx_done), .arp_rx_type(arp_rx_type),
    .src_mac(src_mac), .src_ip(src_ip), .arp_req(arp_req), .udp_busy(udp_busy),
    .arp_tx_en(arp_tx_en), .arp_tx_type(arp_tx_type), .des_mac(des_mac),
    .des_ip(des_ip), .tx_done(tx_done), .arp_busy(arp_busy), .peer_mac(peer_mac),
    .peer_valid(peer_valid), .retry_cnt(retry_cnt)
  );

  typedef struct {
    logic        typ;
    logic [47:0] mac;
    logic [31:0] ip;
    int          rc;   // expected retry_cnt, -1 = don't care
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc;
  int   first_tx = -1;
  int   tx_prev = 0, tx_last = 0, tx_count = 0;
  bit   auto_done = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_req(input int rc);
    exp_t e;
    e.typ = 1'b0; e.mac = BCAST; e.ip = DES_IP; e.rc = rc;
    q.push_back(e);
  endtask

  task automatic push_rep(input logic [47:0] m, input logic [31:0] ip);
    exp_t e;
    e.typ = 1'b1; e.mac = m; e.ip = ip; e.rc = -1;
    q.push_back(e);
  endtask

  task automatic send_rx(input logic typ, input logic [47:0] m, input logic [31:0] ip);
    @(negedge clk);
    arp_rx_done = 1'b1; arp_rx_type = typ; src_mac = m; src_ip = ip;
    @(negedge clk);
    arp_rx_done = 1'b0;
  endtask

  task automatic wait_q_empty(input int budget, input string nm);
    int b;
    b = budget;
    while (q.size() > 0 && b > 0) begin
      @(negedge clk);
      b--;
    end
    chk(nm, 64'(q.size()), 64'd0);
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int b;
    b = budget;
    while (arp_busy && b > 0) begin
      @(negedge clk);
      b--;
    end
    chk(nm, 64'(arp_busy), 64'd0);
  endtask

  // Monitor: every transmit pulse is matched against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && arp_tx_en) begin
        tx_count++;
        tx_prev = tx_last;
        tx_last = cyc;
        if (first_tx < 0) first_tx = cyc;
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_tx: type %0d des_ip %h expected no frame", arp_tx_type, des_ip);
        end else begin
          e = q.pop_front();
          chk("tx_type", 64'(arp_tx_type), 64'(e.typ));
          chk("des_mac", 64'(des_mac), 64'(e.mac));
          chk("des_ip", 64'(des_ip), 64'(e.ip));
          chk("busy_at_tx", 64'(arp_busy), 64'd1);
          if (e.rc >= 0) chk("retry_cnt", 64'(retry_cnt), 64'(e.rc));
        end
      end
    end
  end

  // Stand-in ARP transmitter: completes each frame after a random delay.
  initial begin
    int d;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && arp_tx_en && auto_done) begin
        d = $urandom_range(6, 12);
        repeat (d) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  initial begin
    logic [47:0] m;
    logic [31:0] ip;
    int budget, bad, txc, gap;

    rst_n = 1'b0; arp_rx_done = 1'b0; arp_rx_type = 1'b0; src_mac = '0; src_ip = '0;
    arp_req = 1'b0; udp_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_en", 64'(arp_tx_en), 64'd0);
    chk("rst_busy", 64'(arp_busy), 64'd0);
    chk("rst_peer_valid", 64'(peer_valid), 64'd0);
    chk("rst_retry_cnt", 64'(retry_cnt), 64'd0);
    chk("rst_des_mac", 64'(des_mac), 64'(BCAST));
    chk("rst_des_ip", 64'(des_ip), 64'(DES_IP));
    chk("rst_peer_mac", 64'(peer_mac), 64'd0);

    // Unanswered resolution: 258 requests, counter saturating at 255.
    for (int k = 1; k <= 258; k++) push_req((k > 255) ? 255 : k);
    rst_n = 1'b1;
    budget = 258 * (int'(RETRY) + 20);
    while (q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
      // Replies from foreign IPs must be ignored.
      arp_rx_done = ($urandom_range(0, 49) == 0);
      arp_rx_type = 1'b1;
      src_mac     = {$urandom(), 16'(($urandom()))};
      src_ip      = DES_IP ^ ($urandom() | 32'h1);
    end
    arp_rx_done = 1'b0;
    chk("all_requests_seen", 64'(q.size()), 64'd0);
    chk("first_tx_cycle", 64'(first_tx), 64'(STARTUP + 32'd2));

    // Peer reply resolves the MAC; no more requests afterwards.
    wait_idle(100, "idle_before_resolve");
    repeat (2) @(negedge clk);
    send_rx(1'b1, PEER_MAC, DES_IP);
    chk("peer_valid_set", 64'(peer_valid), 64'd1);
    chk("peer_mac", 64'(peer_mac), 64'(PEER_MAC));
    chk("retry_cnt_held", 64'(retry_cnt), 64'd255);
    txc = tx_count;
    repeat (3 * int'(RETRY)) @(negedge clk);
    chk("no_tx_after_resolve", 64'(tx_count), 64'(txc));

    // Forced resolution, with a board request arriving during WAIT_DONE.
    push_req(1);
    @(negedge clk); arp_req = 1'b1;
    @(negedge clk); arp_req = 1'b0;
    chk("arp_req_clears_valid", 64'(peer_valid), 64'd0);
    chk("arp_req_zero_cnt", 64'(retry_cnt), 64'd0);
    budget = 20;
    while (tx_count == txc && budget > 0) begin @(negedge clk); budget--; end
    chk("forced_req_sent", 64'(tx_count), 64'(txc + 1));
    m = {$urandom(), 16'($urandom())};
    push_rep(m, 32'hc0a80132);
    send_rx(1'b0, m, 32'hc0a80132);
    send_rx(1'b1, PEER_MAC, DES_IP);
    wait_q_empty(100, "reply_after_req");
    wait_idle(50, "idle_after_reply");
    chk("des_ip_held", 64'(des_ip), 64'h0000_0000_c0a80132);
    chk("peer_revalid", 64'(peer_valid), 64'd1);

    // UDP owns the bus while a reply is pending.
    @(negedge clk); udp_busy = 1'b1;
    m = {$urandom(), 16'($urandom())};
    ip = $urandom();
    push_rep(m, ip);
    send_rx(1'b0, m, ip);
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (arp_tx_en || !arp_busy) bad++;
    end
    chk("udp_hold", 64'(bad), 64'd0);
    udp_busy = 1'b0;
    @(negedge clk);
    chk("tx_after_udp_free", 64'(arp_tx_en), 64'd1);
    wait_q_empty(20, "udp_reply_sent");
    wait_idle(50, "idle_after_udp");

    // tx_done never comes: reply resent after the watchdog, then reset.
    auto_done = 1'b0;
    m = {$urandom(), 16'($urandom())};
    ip = $urandom();
    push_rep(m, ip);
    push_rep(m, ip);
    send_rx(1'b0, m, ip);
    wait_q_empty(3 * int'(TXTO) + 50, "timeout_resend");
    gap = tx_last - tx_prev;
    chk("timeout_gap_ok", 64'((gap >= int'(TXTO) + 1) && (gap <= int'(TXTO) + 3)), 64'd1);
    repeat (5) @(negedge clk);
    chk("busy_in_wait_done", 64'(arp_busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(arp_busy), 64'd0);
    chk("mid_rst_tx_en", 64'(arp_tx_en), 64'd0);
    chk("mid_rst_type", 64'(arp_tx_type), 64'd0);
    chk("mid_rst_des_mac", 64'(des_mac), 64'(BCAST));
    chk("mid_rst_des_ip", 64'(des_ip), 64'(DES_IP));
    chk("mid_rst_peer", 64'({peer_valid, retry_cnt}), 64'd0);
    chk("mid_rst_peer_mac", 64'(peer_mac), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
